// File: rtl/fours_enumerator.sv
// fours_enumerator: sweeps every (A,B) pair of W-bit operands and hands out, one at a
// time over a valid/ready port, each pair whose truncated sum and product hit the targets.
module fours_enumerator #(
  parameter int W = 3,
  parameter int TARGET_SUM = 4,
  parameter int TARGET_PROD = 4
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           start,
  input  logic           abort,
  input  logic           sol_ready,
  output logic           busy,
  output logic           done,
  output logic           sol_valid,
  output logic [W-1:0]   sol_a,
  output logic [W-1:0]   sol_b,
  output logic [2*W:0]   sol_count
);
  typedef enum logic [1:0] {IDLE, SCAN, EMIT, DONE} state_t;
  localparam logic [W-1:0] TS = W'(TARGET_SUM);
  localparam logic [W-1:0] TP = W'(TARGET_PROD);
  state_t r_state, w_next;
  logic [2*W-1:0] r_idx;
  logic [2*W:0] r_count;
  logic [W-1:0] r_sol_a, r_sol_b;
  logic [W-1:0] w_a, w_b, w_sum, w_prod;
  logic w_match, w_last, w_step, w_accept, w_load;
  assign w_a = r_idx[2*W-1:W];
  assign w_b = r_idx[W-1:0];
  assign w_sum = w_a + w_b;
  assign w_prod = w_a * w_b;
  assign w_match = (w_sum == TS) && (w_prod == TP);
  assign w_last = &r_idx;
  // abort suppresses every side effect of SCAN/EMIT in the cycle it is seen
  assign w_load = (r_state == SCAN) && !abort && w_match;
  assign w_accept = (r_state == EMIT) && !abort && sol_ready;
  assign w_step = !abort && !w_last && (((r_state == SCAN) && !w_match) || w_accept);
  always_comb begin
    w_next = r_state;
    unique case (r_state)
      IDLE: w_next = start ? SCAN : IDLE;
      SCAN: w_next = abort ? IDLE : w_match ? EMIT : w_last ? DONE : SCAN;
      EMIT: w_next = abort ? IDLE : !sol_ready ? EMIT : w_last ? DONE : SCAN;
      default: w_next = IDLE;
    endcase
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= IDLE;
      r_idx <= '0;
      r_count <= '0;
      r_sol_a <= '0;
      r_sol_b <= '0;
    end else begin
      r_state <= w_next;
      if ((r_state == IDLE) && start) begin
        r_idx <= '0;
        r_count <= '0;
      end
      if (w_step) r_idx <= r_idx + (2*W)'(1);
      if (w_accept) r_count <= r_count + (2*W+1)'(1);
      if (w_load) begin
        r_sol_a <= w_a;
        r_sol_b <= w_b;
      end
    end
  end
  assign busy = (r_state == SCAN) || (r_state == EMIT);
  assign done = (r_state == DONE);
  assign sol_valid = (r_state == EMIT);
  assign sol_a = r_sol_a;
  assign sol_b = r_sol_b;
  assign sol_count = r_count;
endmodule

// File: doc/fours_enumerator.md
FOURS_ENUMERATOR -- requirements
Module: fours_enumerator

Interface
REQ-001 W, 3, operand width in bits; the candidate space is 2^(2W) pairs (A,B).
REQ-002 TARGET_SUM, 4, required value of (A+B) mod 2^W.
REQ-003 TARGET_PROD, 4, required value of (A*B) mod 2^W.
REQ-004 clk  input  1  single clock; all state updates on the rising edge.
REQ-005 rst  input  1  asynchronous, active-high reset.
REQ-006 start  input  1  begin a search; sampled only in IDLE.
REQ-007 abort  input  1  cancel a search in progress; returns to IDLE.
REQ-008 busy  output  1  high in SCAN and EMIT.
REQ-009 done  output  1  one-cycle pulse when the search completes.
REQ-010 sol_valid  output  1  a solution is presented on sol_a/sol_b.
REQ-011 sol_ready  input  1  consumer accepts the solution when high with sol_valid.
REQ-012 sol_a  output  W  A operand of the presented solution.
REQ-013 sol_b  output  W  B operand of the presented solution.
REQ-014 sol_count  output  2W+1  number of solutions accepted in the current or last search.

Function
REQ-015 Block SHALL sweep candidates idx = {A,B}, A in the high W bits, from 0 to 2^(2W)-1, incrementing by 1.
REQ-016 Match SHALL be (A+B) mod 2^W == TARGET_SUM AND (A*B) mod 2^W == TARGET_PROD; all arithmetic truncated to W bits.
REQ-017 States SHALL be IDLE, SCAN, EMIT and DONE.
REQ-018 IDLE, start=1: idx<=0, sol_count<=0, go to SCAN; start is ignored in all other states.
REQ-019 SCAN SHALL evaluate exactly one candidate per cycle.
REQ-020 SCAN on match: register A/B into sol_a/sol_b and go to EMIT.
REQ-021 SCAN with no match and idx = max: go to DONE.
REQ-022 SCAN with no match otherwise: idx<=idx+1 and stay in SCAN.
REQ-023 sol_valid SHALL equal (state==EMIT); sol_a and sol_b SHALL hold stable while sol_valid=1 and sol_ready=0.
REQ-024 EMIT with sol_ready=1: sol_count<=sol_count+1; if idx = max go to DONE, else idx<=idx+1 and go to SCAN.
REQ-025 DONE SHALL assert done for exactly one cycle, then go to IDLE; sol_count SHALL hold until the next start.
REQ-026 abort=1 in SCAN or EMIT SHALL go to IDLE on the next edge with no done pulse and no sol_count increment, even if sol_ready=1 in the same cycle.
REQ-027 abort SHALL have priority over every other transition; abort in IDLE or DONE SHALL have no effect.
REQ-028 busy SHALL equal (state==SCAN or state==EMIT).

Reset
REQ-029 rst=1 SHALL immediately force IDLE, idx=0, sol_count=0, sol_a=0, sol_b=0, and sol_valid, done and busy to 0, regardless of clk.
REQ-030 Reset asserted mid-search SHALL discard the search; after release the block SHALL wait for a new start.

Verification
REQ-031 Defaults, sol_ready held 1, start pulsed at edge 0 -> sol_valid high with (2,2) in cycle 20 and with (6,6) in cycle 57; done pulses in cycle 67; sol_count=2.
REQ-032 Defaults, sol_ready held 0 for 10 cycles after the first sol_valid -> sol_a=2 and sol_b=2 stable throughout; the scan resumes after acceptance; final sol_count=2.
REQ-033 abort asserted during the first EMIT with sol_ready=1 -> IDLE on the next edge, no done pulse, sol_count=0; a new start rescans from idx 0.
REQ-034 start asserted while busy, then a second start after done -> the first is ignored; the second search yields the identical sequence and sol_count=2.
REQ-035 rst pulsed asynchronously between edges during SCAN -> outputs clear immediately; no sol_valid and no done until the next start.
REQ-036 TARGET_SUM=0, TARGET_PROD=0, W=3 -> solutions (0,0) and (4,4) in that order; sol_count=2.
